// File: rtl/celllib_pkg.sv
// Shared cell-library definitions: collector FSM states and the
// timeout counter width used by byte_pair_collector.
package celllib_pkg;

    localparam int CntW = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_FIRST  = 2'd1,
        ST_WAIT_SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/byte_pair_collector.sv
// Collects two strobed bytes into a high/low pair with an idle timeout.
// Ports: Clk_i, Reset_n_i (async, active-low), Start_i, Byte_i,
//        ByteValid_i in; H_o, L_o (last completed pair), Done_o,
//        Busy_o, Error_o (timeout abort pulse) out.
module byte_pair_collector
    import celllib_pkg::*;
#(
    parameter bit          MsbFirst      = 1'b1,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic       Clk_i,
    input  logic       Reset_n_i,
    input  logic       Start_i,
    input  logic [7:0] Byte_i,
    input  logic       ByteValid_i,
    output logic [7:0] H_o,
    output logic [7:0] L_o,
    output logic       Done_o,
    output logic       Busy_o,
    output logic       Error_o
);

    localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);

    state_t          state;
    logic [7:0]      shadow;
    logic [CntW-1:0] cnt;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            cnt     <= '0;
            H_o     <= '0;
            L_o     <= '0;
            Done_o  <= 1'b0;
            Busy_o  <= 1'b0;
            Error_o <= 1'b0;
        end else begin
            Done_o  <= 1'b0;
            Error_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Strobes here are stale, even alongside Start.
                    if (Start_i) begin
                        state  <= ST_WAIT_FIRST;
                        cnt    <= '0;
                        Busy_o <= 1'b1;
                    end
                end
                ST_WAIT_FIRST: begin
                    // A strobe wins over a timeout in the same cycle.
                    if (ByteValid_i) begin
                        shadow <= Byte_i;
                        cnt    <= '0;
                        state  <= ST_WAIT_SECOND;
                    end else if (cnt == TimeoutVal) begin
                        Error_o <= 1'b1;
                        Busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (ByteValid_i) begin
                        // Both halves update on one edge: never partial.
                        if (MsbFirst) begin
                            H_o <= shadow;
                            L_o <= Byte_i;
                        end else begin
                            H_o <= Byte_i;
                            L_o <= shadow;
                        end
                        Done_o <= 1'b1;
                        Busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt == TimeoutVal) begin
                        Error_o <= 1'b1;
                        Busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    Busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_pair_collector.sv
// Directed bench: two collectors (high-first and low-first, timeout 4)
// share one stimulus stream; each cycle both are checked.
module tb_byte_pair_collector;

    typedef struct {
        logic       start;
        logic       bv;
        logic [7:0] data;
        logic [7:0] hm, lm, hl, ll;
        logic       done, busy, err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] data = 8'h00;

    logic [7:0] h_m, l_m, h_l, l_l;
    logic       done_m, busy_m, err_m;
    logic       done_l, busy_l, err_l;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    byte_pair_collector #(.MsbFirst(1'b1), .TimeoutCycles(4)) dut_m (
        .Clk_i(clk), .Reset_n_i(rst_n), .Start_i(start),
        .Byte_i(data), .ByteValid_i(bv),
        .H_o(h_m), .L_o(l_m), .Done_o(done_m),
        .Busy_o(busy_m), .Error_o(err_m)
    );

    byte_pair_collector #(.MsbFirst(1'b0), .TimeoutCycles(4)) dut_l (
        .Clk_i(clk), .Reset_n_i(rst_n), .Start_i(start),
        .Byte_i(data), .ByteValid_i(bv),
        .H_o(h_l), .L_o(l_l), .Done_o(done_l),
        .Busy_o(busy_l), .Error_o(err_l)
    );

    function automatic vec_t mk(
        logic s, logic b, logic [7:0] d,
        logic [7:0] hm, logic [7:0] lm,
        logic [7:0] hl, logic [7:0] ll,
        logic dn, logic bz, logic er
    );
        vec_t v;
        v.start = s;  v.bv = b;   v.data = d;
        v.hm = hm;    v.lm = lm;  v.hl = hl;  v.ll = ll;
        v.done = dn;  v.busy = bz; v.err = er;
        return v;
    endfunction

    task automatic check(input string name, input vec_t v);
        logic [37:0] act, exp;
        act = {h_m, l_m, h_l, l_l,
               done_m, busy_m, err_m, done_l, busy_l, err_l};
        exp = {v.hm, v.lm, v.hl, v.ll,
               v.done, v.busy, v.err, v.done, v.busy, v.err};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got h/l(m)=%h/%h h/l(l)=%h/%h d/b/e(m)=%b%b%b d/b/e(l)=%b%b%b, want h/l(m)=%h/%h h/l(l)=%h/%h d/b/e=%b%b%b",
                     name, h_m, l_m, h_l, l_l,
                     done_m, busy_m, err_m, done_l, busy_l, err_l,
                     v.hm, v.lm, v.hl, v.ll, v.done, v.busy, v.err);
        end
    endtask

    // Drive on the falling edge, check 1 time unit after the rising edge.
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        start = v.start;
        bv    = v.bv;
        data  = v.data;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        vec_t z;

        // Reset state.
        z = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", z);
        @(negedge clk);
        rst_n = 1'b1;
        apply("release", z);

        // Table: pair, ignored strobes/starts, timeout, strobe-at-limit.
        tbl.push_back(mk(0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 0,0,0));
        tbl.push_back(mk(1,1,8'h77, 8'h00,8'h00,8'h00,8'h00, 0,1,0));
        tbl.push_back(mk(0,1,8'hA5, 8'h00,8'h00,8'h00,8'h00, 0,1,0));
        tbl.push_back(mk(0,1,8'h3C, 8'hA5,8'h3C,8'h3C,8'hA5, 1,0,0));
        tbl.push_back(mk(0,0,8'h00, 8'hA5,8'h3C,8'h3C,8'hA5, 0,0,0));
        tbl.push_back(mk(1,0,8'h00, 8'hA5,8'h3C,8'h3C,8'hA5, 0,1,0));
        tbl.push_back(mk(0,1,8'h11, 8'hA5,8'h3C,8'h3C,8'hA5, 0,1,0));
        tbl.push_back(mk(1,0,8'h00, 8'hA5,8'h3C,8'h3C,8'hA5, 0,1,0));
        tbl.push_back(mk(0,1,8'h22, 8'h11,8'h22,8'h22,8'h11, 1,0,0));
        tbl.push_back(mk(1,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        tbl.push_back(mk(0,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,0,1));
        tbl.push_back(mk(0,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,0,0));
        tbl.push_back(mk(1,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        tbl.push_back(mk(0,1,8'h5A, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,8'h00, 8'h11,8'h22,8'h22,8'h11, 0,1,0));
        tbl.push_back(mk(0,1,8'hC3, 8'h5A,8'hC3,8'hC3,8'h5A, 1,0,0));
        tbl.push_back(mk(0,0,8'h00, 8'h5A,8'hC3,8'hC3,8'h5A, 0,0,0));
        tbl.push_back(mk(0,1,8'hEE, 8'h5A,8'hC3,8'hC3,8'h5A, 0,0,0));

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a collection clears everything at once.
        apply("mid_start",
              mk(1,0,8'h00, 8'h5A,8'hC3,8'hC3,8'h5A, 0,1,0));
        apply("mid_first",
              mk(0,1,8'h99, 8'h5A,8'hC3,8'hC3,8'h5A, 0,1,0));
        @(negedge clk);
        start = 1'b0;
        bv    = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_reset", z);
        @(posedge clk);
        #1;
        check("held_reset", z);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_release", z);
        apply("re_start",
              mk(1,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 0,1,0));
        apply("re_first",
              mk(0,1,8'h12, 8'h00,8'h00,8'h00,8'h00, 0,1,0));
        apply("re_second",
              mk(0,1,8'h34, 8'h12,8'h34,8'h34,8'h12, 1,0,0));
        apply("re_idle",
              mk(0,0,8'h00, 8'h12,8'h34,8'h34,8'h12, 0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
